// File: rtl/data_req_scheduler_pkg.sv
// Shared definitions for the data request scheduler: bus size encodings and
// the layout of one in-flight tag entry.
package data_req_scheduler_pkg;

    localparam logic [1:0] SZ_BYTE = 2'd0;
    localparam logic [1:0] SZ_HALF = 2'd1;
    localparam logic [1:0] SZ_WORD = 2'd2;

    // One accepted-but-unanswered request; discard marks a flushed instruction.
    typedef struct packed {
        logic wr;
        logic discard;
    } tag_entry_t;

endpackage

// File: rtl/req_tag_fifo.sv
// In-order tag FIFO for outstanding bus requests, with a flush-mark that can
// exempt the head entry being popped in the same cycle.
module req_tag_fifo
    import data_req_scheduler_pkg::*;
#(
    parameter int DEPTH = 2,
    parameter int CNT_W = 2
) (
    input  logic clk,
    input  logic resetn,
    input  logic push_i,
    input  logic push_wr_i,
    input  logic pop_i,
    input  logic flush_mark_i,
    input  logic head_exempt_i,
    output logic full_o,
    output logic empty_o,
    output logic head_wr_o,
    output logic head_discard_o
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    tag_entry_t [DEPTH-1:0] mem_q, mem_d;
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic [PTR_W-1:0] offset;
    logic do_push, do_pop;

    assign full_o         = (count_q == CNT_W'(DEPTH));
    assign empty_o        = (count_q == '0);
    assign do_push        = push_i && !full_o;
    assign do_pop         = pop_i && !empty_o;
    assign head_wr_o      = mem_q[rd_ptr_q].wr;
    assign head_discard_o = mem_q[rd_ptr_q].discard;

    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        offset   = '0;
        // Distance from the head decides whether slot i currently holds a live entry.
        for (int i = 0; i < DEPTH; i++) begin
            offset = PTR_W'(i) - rd_ptr_q;
            if (flush_mark_i && (CNT_W'(offset) < count_q) &&
                !(head_exempt_i && offset == '0)) begin
                mem_d[i].discard = 1'b1;
            end
        end
        if (do_push) begin
            mem_d[wr_ptr_q] = '{wr: push_wr_i, discard: 1'b0};
            wr_ptr_d        = wr_ptr_q + PTR_W'(1);
        end
        if (do_pop) begin
            rd_ptr_d = rd_ptr_q + PTR_W'(1);
        end
        case ({do_push, do_pop})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            mem_q    <= '0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            mem_q    <= mem_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

endmodule

// File: rtl/data_req_scheduler.sv
// Issues memory-stage requests onto the SRAM-like data bus and routes each
// data_ok back to writeback, suppressing responses of flushed instructions.
module data_req_scheduler
    import data_req_scheduler_pkg::*;
#(
    parameter int MAX_OUTSTANDING = 2,
    parameter int CNT_W           = 2
) (
    input  logic        clk,
    input  logic        resetn,
    input  logic        req_valid,
    input  logic        req_wr,
    input  logic [1:0]  req_size,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        req_ready,
    input  logic        flush,
    output logic        data_req,
    output logic        data_wr,
    output logic [1:0]  data_size,
    output logic [31:0] data_addr,
    output logic [31:0] data_wdata,
    input  logic        data_addr_ok,
    input  logic        data_data_ok,
    input  logic [31:0] data_rdata,
    output logic        resp_valid,
    output logic        resp_wr,
    output logic [31:0] resp_rdata,
    output logic        busy,
    output logic        err_spurious,
    output logic [31:0] perfcnt_issue_stall
);

    // Handshake: a request transfers when data_req && data_addr_ok in the same
    // cycle; a response is consumed on every data_data_ok, with no back-pressure.
    logic full, empty, head_wr, head_discard, pop;
    logic        err_q, err_d;
    logic [31:0] perf_q, perf_d;

    assign data_req   = req_valid && !full && !flush;
    assign data_wr    = req_wr;
    assign data_size  = req_size;
    assign data_addr  = req_addr;
    assign data_wdata = req_wdata;
    assign req_ready  = data_req && data_addr_ok;

    assign pop        = data_data_ok && !empty;
    assign resp_valid = pop && !head_discard;
    assign resp_wr    = head_wr;
    assign resp_rdata = data_rdata;
    assign busy       = !empty;

    req_tag_fifo #(
        .DEPTH(MAX_OUTSTANDING),
        .CNT_W(CNT_W)
    ) u_tag_fifo (
        .clk           (clk),
        .resetn        (resetn),
        .push_i        (req_ready),
        .push_wr_i     (req_wr),
        .pop_i         (pop),
        .flush_mark_i  (flush),
        .head_exempt_i (pop),
        .full_o        (full),
        .empty_o       (empty),
        .head_wr_o     (head_wr),
        .head_discard_o(head_discard)
    );

    always_comb begin
        err_d  = err_q || (data_data_ok && empty);
        perf_d = perf_q;
        if (req_valid && !req_ready) begin
            perf_d = perf_q + 32'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            err_q  <= 1'b0;
            perf_q <= '0;
        end else begin
            err_q  <= err_d;
            perf_q <= perf_d;
        end
    end

    assign err_spurious        = err_q;
    assign perfcnt_issue_stall = perf_q;

endmodule

// File: tb/tb_data_req_scheduler.sv
// Directed bench for data_req_scheduler: a queue-based model checked every
// cycle, plus literal expectations at key points of each scenario.
module tb_data_req_scheduler;

    localparam int MAX = 2;

    logic        clk = 1'b0;
    logic        resetn;
    logic        req_valid, req_wr, flush, data_addr_ok, data_data_ok;
    logic [1:0]  req_size;
    logic [31:0] req_addr, req_wdata, data_rdata;
    logic        req_ready, data_req, data_wr, resp_valid, resp_wr, busy, err_spurious;
    logic [1:0]  data_size;
    logic [31:0] data_addr, data_wdata, resp_rdata, perfcnt_issue_stall;

    int checks = 0;
    int errors = 0;
    bit chk_en = 1'b0;

    // Model state: in-order tags, bit1 = wr, bit0 = discard.
    logic [1:0]  exp_q[$];
    logic        m_err  = 1'b0;
    logic [31:0] m_perf = '0;

    data_req_scheduler #(.MAX_OUTSTANDING(2), .CNT_W(2)) dut (
        .clk(clk), .resetn(resetn),
        .req_valid(req_valid), .req_wr(req_wr), .req_size(req_size),
        .req_addr(req_addr), .req_wdata(req_wdata), .req_ready(req_ready),
        .flush(flush),
        .data_req(data_req), .data_wr(data_wr), .data_size(data_size),
        .data_addr(data_addr), .data_wdata(data_wdata),
        .data_addr_ok(data_addr_ok), .data_data_ok(data_data_ok), .data_rdata(data_rdata),
        .resp_valid(resp_valid), .resp_wr(resp_wr), .resp_rdata(resp_rdata),
        .busy(busy), .err_spurious(err_spurious), .perfcnt_issue_stall(perfcnt_issue_stall)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Model compare, then advance the model to the state after the next edge.
    always @(negedge clk) begin
        logic e_req, e_ready, e_pop, e_rv;
        e_req   = req_valid && (exp_q.size() < MAX) && !flush;
        e_ready = e_req && data_addr_ok;
        e_pop   = data_data_ok && (exp_q.size() != 0);
        e_rv    = e_pop && !exp_q[0][0];
        if (chk_en) begin
            check("m_data_req",   {31'b0, data_req},   {31'b0, e_req});
            check("m_req_ready",  {31'b0, req_ready},  {31'b0, e_ready});
            check("m_data_wr",    {31'b0, data_wr},    {31'b0, req_wr});
            check("m_data_size",  {30'b0, data_size},  {30'b0, req_size});
            check("m_data_addr",  data_addr,           req_addr);
            check("m_data_wdata", data_wdata,          req_wdata);
            check("m_resp_valid", {31'b0, resp_valid}, {31'b0, e_rv});
            if (e_rv) check("m_resp_wr", {31'b0, resp_wr}, {31'b0, exp_q[0][1]});
            check("m_resp_rdata", resp_rdata,          data_rdata);
            check("m_busy",       {31'b0, busy},       {31'b0, exp_q.size() != 0});
            check("m_err",        {31'b0, err_spurious}, {31'b0, m_err});
            check("m_perf",       perfcnt_issue_stall, m_perf);
        end
        if (!resetn) begin
            exp_q.delete();
            m_err  = 1'b0;
            m_perf = '0;
        end else begin
            if (flush) begin
                for (int i = 0; i < exp_q.size(); i++)
                    if (!(i == 0 && e_pop)) exp_q[i][0] = 1'b1;
            end
            if (data_data_ok && exp_q.size() == 0) m_err = 1'b1;
            if (e_pop) void'(exp_q.pop_front());
            if (e_ready) exp_q.push_back({req_wr, 1'b0});
            if (req_valid && !e_ready) m_perf = m_perf + 32'd1;
        end
    end

    task automatic clr();
        req_valid = 0; req_wr = 0; req_size = 2'd2; req_addr = '0; req_wdata = '0;
        flush = 0; data_addr_ok = 0; data_data_ok = 0; data_rdata = '0;
    endtask

    task automatic to_neg();
        @(negedge clk);
    endtask

    task automatic next();
        @(posedge clk); #1;
        clr();
    endtask

    task automatic issue(input logic wr, input logic [31:0] addr);
        req_valid = 1; req_wr = wr; req_addr = addr; data_addr_ok = 1;
        req_wdata = $urandom; req_size = 2'($urandom_range(0, 2));
    endtask

    initial begin
        clr();
        resetn = 0;
        repeat (2) begin @(posedge clk); #1; end
        resetn = 1;
        chk_en = 1;
        to_neg();
        check("rst_data_req", {31'b0, data_req}, 32'd0);
        check("rst_busy", {31'b0, busy}, 32'd0);
        check("rst_err", {31'b0, err_spurious}, 32'd0);
        check("rst_perf", perfcnt_issue_stall, 32'd0);
        next();

        // Single load with data_ok three cycles later.
        issue(0, 32'h100);
        to_neg();
        check("ld_req_ready", {31'b0, req_ready}, 32'd1);
        next();
        to_neg(); check("ld_busy1", {31'b0, busy}, 32'd1); next();
        to_neg(); next();
        data_data_ok = 1; data_rdata = 32'hDEADBEEF;
        to_neg();
        check("ld_resp_valid", {31'b0, resp_valid}, 32'd1);
        check("ld_resp_rdata", resp_rdata, 32'hDEADBEEF);
        next();
        to_neg(); check("ld_busy0", {31'b0, busy}, 32'd0); next();

        // Back-pressure: four requests, only two fit.
        for (int i = 0; i < 4; i++) begin
            issue(i[0], 32'h300 + 32'(i * 4));
            to_neg();
            check("bp_data_req", {31'b0, data_req}, (i < 2) ? 32'd1 : 32'd0);
            if (i == 3) check("bp_perf", perfcnt_issue_stall, 32'd1);
            next();
        end
        to_neg(); check("bp_perf2", perfcnt_issue_stall, 32'd2); next();

        // Full FIFO: pop and push in the same cycle; push stays blocked.
        issue(1, 32'h400);
        data_data_ok = 1; data_rdata = 32'h11111111;
        to_neg();
        check("fp_resp_valid", {31'b0, resp_valid}, 32'd1);
        check("fp_data_req", {31'b0, data_req}, 32'd0);
        next();
        issue(1, 32'h400);
        to_neg(); check("fp_req_ready", {31'b0, req_ready}, 32'd1); next();

        // Flush with head popping: head delivered, second entry dropped.
        issue(0, 32'h500);
        flush = 1; data_data_ok = 1; data_rdata = 32'h22222222;
        to_neg();
        check("fl_head_resp", {31'b0, resp_valid}, 32'd1);
        check("fl_data_req", {31'b0, data_req}, 32'd0);
        next();
        data_data_ok = 1; data_rdata = 32'h33333333;
        to_neg();
        check("fl_disc_resp", {31'b0, resp_valid}, 32'd0);
        check("fl_perf", perfcnt_issue_stall, 32'd4);
        next();
        to_neg(); check("fl_busy0", {31'b0, busy}, 32'd0); next();

        // Flush with no pop: both outstanding entries discarded.
        issue(0, 32'h600); to_neg(); next();
        issue(1, 32'h604); to_neg(); next();
        flush = 1; to_neg(); next();
        for (int i = 0; i < 2; i++) begin
            data_data_ok = 1; data_rdata = 32'h44440000 + 32'(i);
            to_neg(); check("fl2_resp", {31'b0, resp_valid}, 32'd0); next();
        end

        // Spurious response, sticky flag, cleared by reset.
        data_data_ok = 1; data_rdata = 32'h55555555;
        to_neg(); check("sp_resp", {31'b0, resp_valid}, 32'd0); next();
        to_neg(); check("sp_err1", {31'b0, err_spurious}, 32'd1); next();
        to_neg(); check("sp_err2", {31'b0, err_spurious}, 32'd1); next();
        resetn = 0; to_neg(); next();
        resetn = 1;
        to_neg();
        check("sp_err_rst", {31'b0, err_spurious}, 32'd0);
        check("sp_perf_rst", perfcnt_issue_stall, 32'd0);
        next();

        // Ten load/store pairs to wrap the pointers several times.
        for (int i = 0; i < 10; i++) begin
            issue(i[0], 32'h800 + 32'(i * 4));
            to_neg(); check("wr_req_ready", {31'b0, req_ready}, 32'd1); next();
            data_data_ok = 1; data_rdata = $urandom;
            to_neg();
            check("wr_resp_valid", {31'b0, resp_valid}, 32'd1);
            check("wr_resp_wr", {31'b0, resp_wr}, 32'(i & 1));
            next();
        end
        to_neg(); check("wr_busy0", {31'b0, busy}, 32'd0); next();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
